// File: rtl/img_pkg.sv
// Shared constants and types for the image RAM scheduler.
package img_pkg;

    localparam int IMG_W      = 320;
    localparam int IMG_H      = 240;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 8;

    // Frame sequencing states; encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PROC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/img_ram_scheduler_rd_lat_pipe.sv
// Read-return delay line: carries {valid, out-of-range} for RD_LAT cycles so
// the returned data lines up with the RAM read latency.
module rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_oob,
    output logic o_valid,
    output logic o_oob
);

    logic [1:0] r_pipe [RD_LAT];

    // Shift stage 0 from the grant, later stages from their predecessor; reset flushes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= 2'b00;
            end
        end else begin
            r_pipe[0] <= {i_valid, i_oob};
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[RD_LAT-1][1];
    assign o_oob   = r_pipe[RD_LAT-1][0];

endmodule

// File: rtl/img_ram_scheduler.sv
// Image RAM scheduler: arbitrates the single-port frame RAM between the
// loader write stream (never stalled, always wins) and the detection
// engine's reads, and sequences each frame IDLE -> LOAD -> PROC -> DONE.
module img_ram_scheduler
    import img_pkg::*;
#(
    parameter int ADDR_W     = img_pkg::ADDR_W,
    parameter int DATA_W     = img_pkg::DATA_W,
    parameter int IMG_PIXELS = img_pkg::IMG_PIXELS,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_wr_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              pe_rd_req,
    input  logic [ADDR_W-1:0] pe_rd_addr,
    output logic              pe_rd_gnt,
    output logic              pe_rd_valid,
    output logic [DATA_W-1:0] pe_rd_data,
    output logic              pe_start,
    input  logic              pe_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        state,
    output logic              frame_ready,
    output logic [7:0]        frame_cnt,
    output logic              err_oob,
    output logic              err_overrun
);

    localparam logic [ADDR_W-1:0] LP_PIX = ADDR_W'(IMG_PIXELS);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] w_wr_cnt_nxt;
    logic [ADDR_W-1:0] w_wr_cnt_inc;
    logic [7:0]        r_frame_cnt;
    logic [7:0]        w_frame_cnt_nxt;
    logic              r_pe_start;
    logic              r_frame_ready;
    logic              r_err_oob;
    logic              r_err_overrun;

    logic              w_wr_in_rng;
    logic              w_wr_acc;
    logic              w_rd_in_rng;
    logic              w_rd_gnt;
    logic              w_oob_seen;
    logic              w_pipe_valid;
    logic              w_pipe_oob;

    // Address qualification and arbitration: any loader strobe blocks the engine.
    assign w_wr_in_rng = (ld_addr < LP_PIX);
    assign w_wr_acc    = ld_wr_en && w_wr_in_rng;
    assign w_rd_in_rng = (pe_rd_addr < LP_PIX);
    assign w_rd_gnt    = pe_rd_req && !ld_wr_en && (r_state == ST_PROC);
    assign w_oob_seen  = (ld_wr_en && !w_wr_in_rng) || (w_rd_gnt && !w_rd_in_rng);

    // Saturating write counter step, so a stray extra write can never wrap it.
    assign w_wr_cnt_inc = (r_wr_cnt >= LP_PIX) ? LP_PIX : (r_wr_cnt + ADDR_W'(1));

    // RAM port mux: writes take the port; out-of-range accesses never enable the RAM.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = pe_rd_addr;
        ram_wdata = ld_data;
        if (ld_wr_en) begin
            ram_addr = ld_addr;
            ram_en   = w_wr_acc;
            ram_we   = w_wr_acc;
        end else if (w_rd_gnt) begin
            ram_en   = w_rd_in_rng;
        end else begin
            ram_en   = 1'b0;
        end
    end

    // Frame sequencing: next state, write count and completed-frame count.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        case (r_state)
            ST_IDLE: begin
                if (ld_wr_en) begin
                    w_state_nxt  = ST_LOAD;
                    w_wr_cnt_nxt = w_wr_acc ? ADDR_W'(1) : ADDR_W'(0);
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_wr_acc) begin
                    w_wr_cnt_nxt = w_wr_cnt_inc;
                end else begin
                    w_wr_cnt_nxt = r_wr_cnt;
                end
                // Full frame or loader end-of-file: whichever comes first, one transition.
                if ((w_wr_acc && (w_wr_cnt_inc == LP_PIX)) || ld_done) begin
                    w_state_nxt = ST_PROC;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_PROC: begin
                if (pe_done) begin
                    w_state_nxt     = ST_DONE;
                    w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                end else begin
                    w_state_nxt     = ST_PROC;
                end
            end
            ST_DONE: begin
                if (ld_wr_en) begin
                    w_state_nxt  = ST_LOAD;
                    w_wr_cnt_nxt = w_wr_acc ? ADDR_W'(1) : ADDR_W'(0);
                end else begin
                    w_state_nxt  = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and status registers; error flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wr_cnt      <= '0;
            r_frame_cnt   <= 8'd0;
            r_pe_start    <= 1'b0;
            r_frame_ready <= 1'b0;
            r_err_oob     <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_pe_start    <= (w_state_nxt == ST_PROC) && (r_state != ST_PROC);
            r_frame_ready <= (w_state_nxt == ST_DONE);
            r_err_oob     <= r_err_oob | w_oob_seen;
            r_err_overrun <= r_err_overrun | (ld_wr_en && (r_state == ST_PROC));
        end
    end

    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_rd_gnt),
        .i_oob   (w_rd_gnt && !w_rd_in_rng),
        .o_valid (w_pipe_valid),
        .o_oob   (w_pipe_oob)
    );

    // Returned data is forced to zero for reads that were flagged out of range.
    always_comb begin
        if (w_pipe_oob) begin
            pe_rd_data = '0;
        end else begin
            pe_rd_data = ram_rdata;
        end
    end

    assign pe_rd_gnt   = w_rd_gnt;
    assign pe_rd_valid = w_pipe_valid;
    assign pe_start    = r_pe_start;
    assign state       = r_state;
    assign frame_ready = r_frame_ready;
    assign frame_cnt   = r_frame_cnt;
    assign err_oob     = r_err_oob;
    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_img_ram_scheduler.sv
// Directed bench for img_ram_scheduler: instance a (RD_LAT=1) with a RAM
// model for the frame/read scenarios, instance b (RD_LAT=3) for mid-frame reset.
module tb_img_ram_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance a ----------------
    logic        a_reset = 1'b1;
    logic        a_ld_wr_en = 1'b0;
    logic [19:0] a_ld_addr = 20'd0;
    logic [7:0]  a_ld_data = 8'd0;
    logic        a_ld_done = 1'b0;
    logic        a_pe_rd_req = 1'b0;
    logic [19:0] a_pe_rd_addr = 20'd0;
    logic        a_pe_done = 1'b0;
    logic        a_pe_rd_gnt, a_pe_rd_valid, a_pe_start;
    logic [7:0]  a_pe_rd_data;
    logic        a_ram_en, a_ram_we;
    logic [19:0] a_ram_addr;
    logic [7:0]  a_ram_wdata;
    logic [7:0]  a_ram_rdata = 8'd0;
    logic [1:0]  a_state;
    logic        a_frame_ready, a_err_oob, a_err_overrun;
    logic [7:0]  a_frame_cnt;

    img_ram_scheduler #(.RD_LAT(1)) dut (
        .clk(clk), .reset(a_reset),
        .ld_wr_en(a_ld_wr_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data), .ld_done(a_ld_done),
        .pe_rd_req(a_pe_rd_req), .pe_rd_addr(a_pe_rd_addr), .pe_rd_gnt(a_pe_rd_gnt),
        .pe_rd_valid(a_pe_rd_valid), .pe_rd_data(a_pe_rd_data), .pe_start(a_pe_start),
        .pe_done(a_pe_done), .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .state(a_state),
        .frame_ready(a_frame_ready), .frame_cnt(a_frame_cnt),
        .err_oob(a_err_oob), .err_overrun(a_err_overrun)
    );

    // Single-port RAM model with one cycle of read latency; rdata holds when idle.
    logic [7:0] mem [0:(1<<20)-1];
    always @(posedge clk) begin
        if (a_ram_en && a_ram_we) begin
            mem[a_ram_addr] <= a_ram_wdata;
        end else if (a_ram_en) begin
            a_ram_rdata <= mem[a_ram_addr];
        end
    end

    // ---------------- instance b ----------------
    logic        b_reset = 1'b1;
    logic        b_ld_wr_en = 1'b0;
    logic [19:0] b_ld_addr = 20'd0;
    logic [7:0]  b_ld_data = 8'd0;
    logic        b_ld_done = 1'b0;
    logic        b_pe_rd_req = 1'b0;
    logic [19:0] b_pe_rd_addr = 20'd0;
    logic        b_pe_done = 1'b0;
    logic        b_pe_rd_gnt, b_pe_rd_valid, b_pe_start;
    logic [7:0]  b_pe_rd_data;
    logic        b_ram_en, b_ram_we;
    logic [19:0] b_ram_addr;
    logic [7:0]  b_ram_wdata;
    logic [7:0]  b_ram_rdata = 8'hAA;
    logic [1:0]  b_state;
    logic        b_frame_ready, b_err_oob, b_err_overrun;
    logic [7:0]  b_frame_cnt;

    img_ram_scheduler #(.RD_LAT(3)) dut_b (
        .clk(clk), .reset(b_reset),
        .ld_wr_en(b_ld_wr_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_done(b_ld_done),
        .pe_rd_req(b_pe_rd_req), .pe_rd_addr(b_pe_rd_addr), .pe_rd_gnt(b_pe_rd_gnt),
        .pe_rd_valid(b_pe_rd_valid), .pe_rd_data(b_pe_rd_data), .pe_start(b_pe_start),
        .pe_done(b_pe_done), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .state(b_state),
        .frame_ready(b_frame_ready), .frame_cnt(b_frame_cnt),
        .err_oob(b_err_oob), .err_overrun(b_err_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after new inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        int v;
        logic seen_valid;

        // ---- reset state ----
        tick(); tick();
        a_reset = 1'b0;
        settle();
        check("rst_state",    32'(a_state), 32'd0);
        check("rst_ready",    32'(a_frame_ready), 32'd0);
        check("rst_fcnt",     32'(a_frame_cnt), 32'd0);
        check("rst_oob",      32'(a_err_oob), 32'd0);
        check("rst_overrun",  32'(a_err_overrun), 32'd0);
        check("rst_start",    32'(a_pe_start), 32'd0);
        check("rst_valid",    32'(a_pe_rd_valid), 32'd0);
        check("rst_ram_en",   32'(a_ram_en), 32'd0);

        // ---- out-of-range write in IDLE: RAM untouched, flag set, LOAD with count 0 ----
        a_ld_wr_en = 1'b1; a_ld_addr = 20'd80000; a_ld_data = 8'h77;
        settle();
        check("oobw_ram_en",  32'(a_ram_en), 32'd0);
        tick();
        check("oobw_flag",    32'(a_err_oob), 32'd1);
        check("oobw_state",   32'(a_state), 32'd1);
        check("oobw_wrcnt",   32'(dut.r_wr_cnt), 32'd0);

        // ---- full frame: 76800 writes, data (addr-4)*17 so 5,6,7 hold 11,22,33 ----
        for (int i = 0; i < 76800; i++) begin
            a_ld_wr_en = 1'b1;
            a_ld_addr  = 20'(i);
            v          = (i - 4) * 17;
            a_ld_data  = v[7:0];
            if (i == 0) begin
                settle();
                check("wr0_en",    32'(a_ram_en), 32'd1);
                check("wr0_we",    32'(a_ram_we), 32'd1);
                check("wr0_addr",  32'(a_ram_addr), 32'd0);
                check("wr0_wdata", 32'(a_ram_wdata), 32'h000000BC);
            end
            if (i == 76799) begin
                settle();
                check("last_wr_state", 32'(a_state), 32'd1);
            end
            tick();
        end
        a_ld_wr_en = 1'b0;
        settle();
        check("full_state",  32'(a_state), 32'd2);
        check("full_start",  32'(a_pe_start), 32'd1);
        check("full_wrcnt",  32'(dut.r_wr_cnt), 32'd76800);
        tick();
        check("start_pulse", 32'(a_pe_start), 32'd0);
        check("proc_hold",   32'(a_state), 32'd2);

        // ---- back-to-back reads at 5,6,7 ----
        a_pe_rd_req = 1'b1; a_pe_rd_addr = 20'd5;
        settle();
        check("rd5_gnt",  32'(a_pe_rd_gnt), 32'd1);
        check("rd5_en",   32'(a_ram_en), 32'd1);
        check("rd5_we",   32'(a_ram_we), 32'd0);
        check("rd5_addr", 32'(a_ram_addr), 32'd5);
        tick();
        a_pe_rd_addr = 20'd6;
        settle();
        check("rd6_gnt",   32'(a_pe_rd_gnt), 32'd1);
        check("rd5_valid", 32'(a_pe_rd_valid), 32'd1);
        check("rd5_data",  32'(a_pe_rd_data), 32'h11);
        tick();
        a_pe_rd_addr = 20'd7;
        settle();
        check("rd7_gnt",   32'(a_pe_rd_gnt), 32'd1);
        check("rd6_valid", 32'(a_pe_rd_valid), 32'd1);
        check("rd6_data",  32'(a_pe_rd_data), 32'h22);
        tick();
        a_pe_rd_req = 1'b0;
        settle();
        check("rd7_valid", 32'(a_pe_rd_valid), 32'd1);
        check("rd7_data",  32'(a_pe_rd_data), 32'h33);
        tick();
        check("rd_idle_valid", 32'(a_pe_rd_valid), 32'd0);

        // ---- contention: write wins, overrun flagged, read granted next cycle ----
        a_pe_rd_req = 1'b1; a_pe_rd_addr = 20'd10;
        a_ld_wr_en = 1'b1; a_ld_addr = 20'd3; a_ld_data = 8'h99;
        settle();
        check("cont_gnt",  32'(a_pe_rd_gnt), 32'd0);
        check("cont_we",   32'(a_ram_we), 32'd1);
        check("cont_addr", 32'(a_ram_addr), 32'd3);
        tick();
        a_ld_wr_en = 1'b0; a_pe_rd_addr = 20'd3;
        settle();
        check("cont_overrun", 32'(a_err_overrun), 32'd1);
        check("cont_state",   32'(a_state), 32'd2);
        check("cont_gnt2",    32'(a_pe_rd_gnt), 32'd1);
        tick();
        a_pe_rd_req = 1'b0;
        settle();
        check("cont_valid", 32'(a_pe_rd_valid), 32'd1);
        check("cont_data",  32'(a_pe_rd_data), 32'h99);

        // ---- out-of-range read: granted, RAM idle, returns zero ----
        a_pe_rd_req = 1'b1; a_pe_rd_addr = 20'd76800;
        settle();
        check("oobr_gnt",    32'(a_pe_rd_gnt), 32'd1);
        check("oobr_ram_en", 32'(a_ram_en), 32'd0);
        tick();
        a_pe_rd_req = 1'b0;
        settle();
        check("oobr_valid", 32'(a_pe_rd_valid), 32'd1);
        check("oobr_data",  32'(a_pe_rd_data), 32'd0);

        // ---- frame done, DONE ignores pe_done ----
        a_pe_done = 1'b1;
        tick();
        check("done_state", 32'(a_state), 32'd3);
        check("done_ready", 32'(a_frame_ready), 32'd1);
        check("done_fcnt",  32'(a_frame_cnt), 32'd1);
        tick();
        a_pe_done = 1'b0;
        check("done_hold_state", 32'(a_state), 32'd3);
        check("done_hold_fcnt",  32'(a_frame_cnt), 32'd1);

        // ---- new frame: 100 writes then ld_done ----
        for (int i = 0; i < 100; i++) begin
            a_ld_wr_en = 1'b1;
            a_ld_addr  = 20'(1000 + i);
            a_ld_data  = 8'(i);
            tick();
            if (i == 0) begin
                check("nf_state", 32'(a_state), 32'd1);
                check("nf_ready", 32'(a_frame_ready), 32'd0);
                check("nf_wrcnt", 32'(dut.r_wr_cnt), 32'd1);
            end
        end
        a_ld_wr_en = 1'b0; a_ld_done = 1'b1;
        tick();
        a_ld_done = 1'b0;
        check("early_state", 32'(a_state), 32'd2);
        check("early_start", 32'(a_pe_start), 32'd1);
        check("early_wrcnt", 32'(dut.r_wr_cnt), 32'd100);

        // ---- pe_done together with a loader write ----
        a_pe_done = 1'b1; a_ld_wr_en = 1'b1; a_ld_addr = 20'd2; a_ld_data = 8'h5C;
        settle();
        check("pdw_we", 32'(a_ram_we), 32'd1);
        tick();
        a_pe_done = 1'b0; a_ld_wr_en = 1'b0;
        check("pdw_state", 32'(a_state), 32'd3);
        check("pdw_fcnt",  32'(a_frame_cnt), 32'd2);
        check("pdw_mem",   32'(mem[2]), 32'h5C);

        // ---- instance b: reset in PROC with two reads in flight ----
        b_reset = 1'b0;
        b_ld_wr_en = 1'b1; b_ld_addr = 20'd1;
        tick();
        b_ld_wr_en = 1'b0; b_ld_done = 1'b1;
        tick();
        b_ld_done = 1'b0;
        check("b_proc_state", 32'(b_state), 32'd2);
        b_ld_wr_en = 1'b1; b_ld_addr = 20'd2;
        tick();
        b_ld_wr_en = 1'b0;
        check("b_overrun", 32'(b_err_overrun), 32'd1);
        b_pe_rd_req = 1'b1; b_pe_rd_addr = 20'd1;
        tick();
        b_pe_rd_addr = 20'd76800;
        tick();
        b_pe_rd_req = 1'b0;
        settle();
        check("b_oob",       32'(b_err_oob), 32'd1);
        check("b_no_early",  32'(b_pe_rd_valid), 32'd0);
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            seen_valid = seen_valid | b_pe_rd_valid;
            tick();
        end
        check("b_flush_valid", 32'(seen_valid), 32'd0);
        check("b_rst_state",   32'(b_state), 32'd0);
        check("b_rst_oob",     32'(b_err_oob), 32'd0);
        check("b_rst_overrun", 32'(b_err_overrun), 32'd0);
        check("b_rst_fcnt",    32'(b_frame_cnt), 32'd0);
        check("b_rst_start",   32'(b_pe_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
